// File: rtl/pc_stack_unit.sv
// pc_stack_unit: parametrised program counter with relative branch, stall and
// call/return through an internal return-address stack.
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous active-high reset
//   stall        freeze all state this cycle
//   incr         advance pc by STEP
//   load         absolute jump to pcin
//   pcin         absolute target for load and call
//   branch       relative jump by offset
//   offset       signed two's-complement branch offset, relative to pcout
//   call         push pcout+STEP, jump to pcin
//   ret          pop return address into pc
//   pcout        current program counter (registered)
//   stack_empty  stack holds no entries
//   stack_full   stack holds STACK_DEPTH entries
//   stack_err    one-cycle pulse after an overflow or underflow attempt
//
// Strobe priority, highest first: stall > ret > call > load > branch > incr.

module pc_stack_unit #(
    parameter int unsigned     WIDTH        = 8,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int unsigned     STEP         = 1,
    parameter int unsigned     STACK_DEPTH  = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall,
    input  logic             incr,
    input  logic             load,
    input  logic [WIDTH-1:0] pcin,
    input  logic             branch,
    input  logic [WIDTH-1:0] offset,
    input  logic             call,
    input  logic             ret,
    output logic [WIDTH-1:0] pcout,
    output logic             stack_empty,
    output logic             stack_full,
    output logic             stack_err
);

    // Count must represent 0..STACK_DEPTH inclusive; index covers 0..STACK_DEPTH-1.
    localparam int unsigned CW = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             push;
    logic [WIDTH-1:0] ret_addr;
    logic [IW-1:0]    top_idx;
    logic [IW-1:0]    push_idx;
    logic [WIDTH-1:0] stack [STACK_DEPTH];

    assign ret_addr    = pc_q + STEP_W;
    assign top_idx     = IW'(cnt_q - CW'(1));
    assign push_idx    = IW'(cnt_q);
    assign stack_empty = (cnt_q == '0);
    assign stack_full  = (cnt_q == CW'(STACK_DEPTH));
    assign pcout       = pc_q;
    assign stack_err   = err_q;

    always_comb begin
        pc_d  = pc_q;
        cnt_d = cnt_q;
        err_d = 1'b0;
        push  = 1'b0;
        if (stall) begin
            // hold everything
        end else if (ret) begin
            if (!stack_empty) begin
                pc_d  = stack[top_idx];
                cnt_d = cnt_q - CW'(1);
            end else begin
                // Underflow: behave like a plain advance and flag it.
                pc_d  = ret_addr;
                err_d = 1'b1;
            end
        end else if (call) begin
            if (!stack_full) begin
                push  = 1'b1;
                cnt_d = cnt_q + CW'(1);
                pc_d  = pcin;
            end else begin
                // Overflow: drop the push and the jump, just advance.
                pc_d  = ret_addr;
                err_d = 1'b1;
            end
        end else if (load) begin
            pc_d = pcin;
        end else if (branch) begin
            pc_d = pc_q + offset;
        end else if (incr) begin
            pc_d = ret_addr;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q  <= RESET_VECTOR;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    // Entry contents need no reset; only the count defines validity.
    always_ff @(posedge clock) begin
        if (push) begin
            stack[push_idx] <= ret_addr;
        end
    end

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed bench for pc_stack_unit (WIDTH=8, STEP=1, STACK_DEPTH=4, RESET_VECTOR=0).
// Each step pushes its expected outputs to a scoreboard queue when driven and
// pops/compares them one time unit after the clock edge that applies it.

module tb_pc_stack_unit;

    logic       clock = 1'b0;
    logic       reset;
    logic       stall, incr, load, branch, call, ret;
    logic [7:0] pcin, offset;
    logic [7:0] pcout;
    logic       stack_empty, stack_full, stack_err;

    int total = 0;
    int bad   = 0;

    // op bitmask: {stall, ret, call, load, branch, incr}
    localparam logic [5:0] NONE = 6'b000000;
    localparam logic [5:0] INC  = 6'b000001;
    localparam logic [5:0] BR   = 6'b000010;
    localparam logic [5:0] LD   = 6'b000100;
    localparam logic [5:0] CL   = 6'b001000;
    localparam logic [5:0] RT   = 6'b010000;
    localparam logic [5:0] ST   = 6'b100000;

    typedef struct {
        string      tag;
        logic [7:0] pc;
        logic       empty;
        logic       full;
        logic       err;
    } exp_t;

    exp_t sb[$];

    pc_stack_unit #(
        .WIDTH       (8),
        .RESET_VECTOR(8'h00),
        .STEP        (1),
        .STACK_DEPTH (4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .stall      (stall),
        .incr       (incr),
        .load       (load),
        .pcin       (pcin),
        .branch     (branch),
        .offset     (offset),
        .call       (call),
        .ret        (ret),
        .pcout      (pcout),
        .stack_empty(stack_empty),
        .stack_full (stack_full),
        .stack_err  (stack_err)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic expect_out(input string tag, input logic [7:0] pc, input logic e,
                              input logic f, input logic er);
        exp_t x;
        x.tag   = tag;
        x.pc    = pc;
        x.empty = e;
        x.full  = f;
        x.err   = er;
        sb.push_back(x);
    endtask

    task automatic sample();
        exp_t x;
        total++;
        assert (sb.size() != 0) else begin
            bad++;
            $error("FAIL scoreboard: got empty queue want entry");
        end
        if (sb.size() != 0) begin
            x = sb.pop_front();
            total++;
            assert (pcout === x.pc) else begin
                bad++;
                $error("FAIL %s pcout: got %h want %h", x.tag, pcout, x.pc);
            end
            total++;
            assert (stack_empty === x.empty) else begin
                bad++;
                $error("FAIL %s stack_empty: got %b want %b", x.tag, stack_empty, x.empty);
            end
            total++;
            assert (stack_full === x.full) else begin
                bad++;
                $error("FAIL %s stack_full: got %b want %b", x.tag, stack_full, x.full);
            end
            total++;
            assert (stack_err === x.err) else begin
                bad++;
                $error("FAIL %s stack_err: got %b want %b", x.tag, stack_err, x.err);
            end
        end
    endtask

    task automatic step(input logic [5:0] ops, input logic [7:0] pi, input logic [7:0] off,
                        input string tag, input logic [7:0] pc, input logic e,
                        input logic f, input logic er);
        {stall, ret, call, load, branch, incr} = ops;
        pcin   = pi;
        offset = off;
        expect_out(tag, pc, e, f, er);
        @(posedge clock);
        #1;
        sample();
    endtask

    initial begin
        reset = 1'b1;
        {stall, ret, call, load, branch, incr} = NONE;
        pcin   = 8'h00;
        offset = 8'h00;
        #2;
        expect_out("reset", 8'h00, 1'b1, 1'b0, 1'b0);
        sample();
        @(posedge clock);
        #1;
        reset = 1'b0;

        // 1: increment and wrap
        step(INC, 8'h00, 8'h00, "incr1", 8'h01, 1, 0, 0);
        step(INC, 8'h00, 8'h00, "incr2", 8'h02, 1, 0, 0);
        step(INC, 8'h00, 8'h00, "incr3", 8'h03, 1, 0, 0);
        step(LD,  8'hFF, 8'h00, "loadff", 8'hFF, 1, 0, 0);
        step(INC, 8'h00, 8'h00, "wrap", 8'h00, 1, 0, 0);
        step(NONE, 8'h00, 8'h00, "hold", 8'h00, 1, 0, 0);

        // 2: branch, priority, stall
        step(LD, 8'h10, 8'h00, "load10", 8'h10, 1, 0, 0);
        step(BR, 8'h00, 8'hFC, "brneg", 8'h0C, 1, 0, 0);
        step(BR | INC, 8'h00, 8'h05, "brwins", 8'h11, 1, 0, 0);
        step(ST | LD | INC | BR, 8'h77, 8'h05, "stall", 8'h11, 1, 0, 0);

        // 3: nested call/return
        step(LD, 8'h20, 8'h00, "load20", 8'h20, 1, 0, 0);
        step(CL, 8'h80, 8'h00, "call80", 8'h80, 0, 0, 0);
        step(INC, 8'h00, 8'h00, "inc81", 8'h81, 0, 0, 0);
        step(CL, 8'h90, 8'h00, "call90", 8'h90, 0, 0, 0);
        step(RT, 8'h00, 8'h00, "ret82", 8'h82, 0, 0, 0);
        step(RT, 8'h00, 8'h00, "ret21", 8'h21, 1, 0, 0);

        // 4: fill, overflow, unwind
        step(CL, 8'hA0, 8'h00, "callA0", 8'hA0, 0, 0, 0);
        step(CL, 8'hB0, 8'h00, "callB0", 8'hB0, 0, 0, 0);
        step(CL, 8'hC0, 8'h00, "callC0", 8'hC0, 0, 0, 0);
        step(CL, 8'hD0, 8'h00, "callD0", 8'hD0, 0, 1, 0);
        step(LD, 8'h55, 8'h00, "load55", 8'h55, 0, 1, 0);
        step(CL, 8'h40, 8'h00, "ovf", 8'h56, 0, 1, 1);
        step(RT, 8'h00, 8'h00, "retC1", 8'hC1, 0, 0, 0);
        step(RT, 8'h00, 8'h00, "retB1", 8'hB1, 0, 0, 0);
        step(RT, 8'h00, 8'h00, "retA1", 8'hA1, 0, 0, 0);
        step(RT, 8'h00, 8'h00, "ret22", 8'h22, 1, 0, 0);

        // 5: underflow, ret over call, back-to-back errors
        step(LD, 8'h30, 8'h00, "load30", 8'h30, 1, 0, 0);
        step(RT, 8'h00, 8'h00, "unf1", 8'h31, 1, 0, 1);
        step(NONE, 8'h00, 8'h00, "errclr", 8'h31, 1, 0, 0);
        step(RT | CL, 8'h99, 8'h00, "retcall", 8'h32, 1, 0, 1);
        step(RT, 8'h00, 8'h00, "unf2", 8'h33, 1, 0, 1);
        step(RT, 8'h00, 8'h00, "unf3", 8'h34, 1, 0, 1);
        step(NONE, 8'h00, 8'h00, "errclr2", 8'h34, 1, 0, 0);

        // return address wraps
        step(LD, 8'hFF, 8'h00, "loadff2", 8'hFF, 1, 0, 0);
        step(CL, 8'h10, 8'h00, "callwrap", 8'h10, 0, 0, 0);
        step(RT, 8'h00, 8'h00, "retwrap", 8'h00, 1, 0, 0);

        // 6: asynchronous reset mid-cycle
        step(CL, 8'h40, 8'h00, "call40", 8'h40, 0, 0, 0);
        step(CL, 8'h50, 8'h00, "call50", 8'h50, 0, 0, 0);
        {stall, ret, call, load, branch, incr} = NONE;
        #2;
        reset = 1'b1;
        #1;
        expect_out("asyncrst", 8'h00, 1'b1, 1'b0, 1'b0);
        sample();
        @(posedge clock);
        #1;
        reset = 1'b0;
        step(RT, 8'h00, 8'h00, "unfrst", 8'h01, 1, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_stack_unit.md
Name: pc_stack_unit

Overview:
- Parametrised program counter for the 8-bit CPU datapath.
- Adds a configurable width, reset vector and increment step.
- Adds a relative branch, a stall input, and call/return through an internal return-address stack.
- Sits between the controller (op strobes) and instruction memory (reads pcout as fetch address).

Parameters:
- WIDTH, 8, PC and address width in bits.
- RESET_VECTOR, 0, pcout value loaded on reset.
- STEP, 1, increment added per normal advance and used for return address.
- STACK_DEPTH, 4, number of return-address entries (>=1).

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  freeze all state this cycle.
- incr  input  1  advance pc by STEP.
- load  input  1  absolute jump to pcin.
- pcin  input  WIDTH  absolute target for load and call.
- branch  input  1  relative jump.
- offset  input  WIDTH  signed two's-complement branch offset, relative to current pcout.
- call  input  1  push return address, jump to pcin.
- ret  input  1  pop return address into pc.
- pcout  output  WIDTH  current program counter (registered).
- stack_empty  output  1  stack holds 0 entries.
- stack_full  output  1  stack holds STACK_DEPTH entries.
- stack_err  output  1  one-cycle pulse on overflow or underflow attempt (registered).

Behaviour:
- Reset, asynchronous, takes effect immediately regardless of clock:
  - pcout=RESET_VECTOR, stack count=0, stack_err=0.
  - stack_empty=1, stack_full=0.
  - Stack entry contents don't-care.
- All updates on the rising clock edge; single-cycle latency.
  - An op sampled at edge N shows on pcout after edge N.
- Priority when several strobes are high, highest first: stall > ret > call > load > branch > incr > hold.
  - stall: pcout, stack and count held; stack_err=0 next cycle.
  - ret, count>0: pcout<=stack[top]; count-1.
  - ret, count=0 (underflow): pcout<=pcout+STEP; count unchanged; stack_err=1 next cycle.
  - call, count<STACK_DEPTH: stack[count]<=pcout+STEP; count+1; pcout<=pcin.
  - call, count=STACK_DEPTH (overflow): no push; pcout<=pcout+STEP; stack_err=1 next cycle.
  - load: pcout<=pcin.
  - branch: pcout<=pcout+offset.
  - incr: pcout<=pcout+STEP.
  - No strobe: pcout held.
- Arithmetic:
  - All sums are modulo 2^WIDTH; wrap-around is silent, with no flag.
  - The return address also wraps (pcout=2^WIDTH-1, STEP=1 pushes 0).
- Stack:
  - LIFO; top = entry count-1.
  - stack_empty and stack_full are decoded combinationally from the registered count.
- stack_err:
  - Registered; high for exactly one cycle after the offending edge.
  - 0 on every cycle with no error; back-to-back errors give consecutive high cycles.
- Lower-priority strobes in the same cycle are ignored, with no side effects.
- Reset asserted mid-operation abandons any op and clears the stack count.
- Release of reset is synchronous to the next edge; the first op applies at the first edge with reset low.

Test Plan (WIDTH=8, STEP=1, STACK_DEPTH=4, RESET_VECTOR=0):
1. Reset, then incr high for 3 edges -> pcout 0x00,0x01,0x02,0x03; stack_empty=1, stack_err=0. Set pcin=0xFF with load, then incr -> 0xFF then wraps to 0x00.
2. pcout=0x10, branch offset=0xFC (-4) -> 0x0C. Then offset=0x05 with branch and incr both high -> 0x11 (branch wins). Then stall with load/incr/branch high -> 0x11 held.
3. From pcout=0x20, call pcin=0x80 -> pcout 0x80, stack_empty=0. incr to 0x81, call pcin=0x90 -> 0x90. ret -> 0x82. ret -> 0x21, stack_empty=1.
4. Four calls fill the stack (stack_full=1). A fifth call pcin=0x40 at pcout=0x55 -> pcout 0x56, stack_err high one cycle, count stays 4. Four rets then return the pushed addresses in reverse order.
5. Empty stack at pcout=0x30, ret -> pcout 0x31, stack_err pulse; ret with call both high -> ret path taken. Two consecutive underflow rets -> stack_err high two cycles.
6. Two entries pushed, reset asserted between clock edges -> pcout=0x00, stack_empty=1 immediately (before next edge). After release, ret -> underflow pulse, pcout 0x01.
